// File: rtl/insn_sequencer.sv
// Control stage for the 4-bit register/adder datapath: a 16x8 program memory,
// program counter and carry flag, decoding one instruction per RUN cycle.
module insn_sequencer (
  input  logic       ck,
  input  logic       res,
  input  logic       start,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic       carry_in,
  output logic [1:0] sel,
  output logic [3:0] imm,
  output logic [3:0] load,
  output logic [3:0] pc,
  output logic       busy,
  output logic       halted,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD_A = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A  = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B = 4'b0101;
  localparam logic [3:0] OP_IN_B  = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_HLT   = 4'b1000;
  localparam logic [3:0] OP_OUT_B = 4'b1001;
  localparam logic [3:0] OP_OUT_I = 4'b1011;
  localparam logic [3:0] OP_JNC   = 4'b1110;
  localparam logic [3:0] OP_JMP   = 4'b1111;

  localparam logic [3:0] LD_A   = 4'b0001;
  localparam logic [3:0] LD_B   = 4'b0010;
  localparam logic [3:0] LD_OUT = 4'b0100;
  localparam logic [3:0] LD_NONE = 4'b0000;

  localparam logic [1:0] SEL_A   = 2'd0;
  localparam logic [1:0] SEL_B   = 2'd1;
  localparam logic [1:0] SEL_SW  = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  state_t     state;
  state_t     state_next;
  logic [7:0] mem [16];
  logic       carry_flag;
  logic [7:0] insn;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic [3:0] pc_next;
  logic       halt_hit;
  logic       launch;

  assign insn    = mem[pc];
  assign opcode  = insn[7:4];
  assign operand = insn[3:0];
  assign launch  = (state != RUN) && start;

  // Program memory has no reset so a loaded program survives res.
  always_ff @(posedge ck) begin
    if (!res && prog_we && (state != RUN)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    sel      = SEL_A;
    imm      = 4'd0;
    load     = LD_NONE;
    pc_next  = pc + 4'd1;
    halt_hit = 1'b0;
    if (state == RUN) begin
      case (opcode)
        OP_ADD_A:  begin sel = SEL_A;    load = LD_A;   imm = operand; end
        OP_ADD_B:  begin sel = SEL_B;    load = LD_B;   imm = operand; end
        OP_MOV_AI: begin sel = SEL_ZERO; load = LD_A;   imm = operand; end
        OP_MOV_BI: begin sel = SEL_ZERO; load = LD_B;   imm = operand; end
        OP_MOV_AB: begin sel = SEL_B;    load = LD_A;   end
        OP_MOV_BA: begin sel = SEL_A;    load = LD_B;   end
        OP_IN_A:   begin sel = SEL_SW;   load = LD_A;   end
        OP_IN_B:   begin sel = SEL_SW;   load = LD_B;   end
        OP_OUT_B:  begin sel = SEL_B;    load = LD_OUT; end
        OP_OUT_I:  begin sel = SEL_ZERO; load = LD_OUT; imm = operand; end
        OP_JMP:    begin sel = SEL_ZERO; pc_next = operand; end
        OP_JNC: begin
          sel = SEL_ZERO;
          // The flag holds the carry of the previous instruction.
          if (!carry_flag) pc_next = operand;
        end
        OP_HLT: begin
          sel      = SEL_ZERO;
          pc_next  = pc;
          halt_hit = 1'b1;
        end
        default: sel = SEL_ZERO;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      HALT:    if (start) state_next = RUN;
      RUN:     if (halt_hit) state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (res) begin
      state      <= IDLE;
      pc         <= 4'd0;
      carry_flag <= 1'b0;
    end else begin
      state <= state_next;
      if (launch) begin
        pc         <= 4'd0;
        carry_flag <= 1'b0;
      end else if (state == RUN) begin
        pc <= pc_next;
        if (!halt_hit) carry_flag <= carry_in;
      end
    end
  end

  assign busy      = (state == RUN);
  assign halted    = (state == HALT);
  assign fsm_state = state;

endmodule

// File: tb/tb_insn_sequencer.sv
// Bench for insn_sequencer: directed program scenarios plus randomized
// programs, all checked each cycle against an instruction-level model.
module tb_insn_sequencer;

  logic       ck = 1'b0;
  logic       res, start, prog_we, carry_in;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [1:0] sel;
  logic [3:0] imm, load, pc;
  logic       busy, halted;
  logic [1:0] fsm_state;

  int vectors = 0;
  int miscompares = 0;

  insn_sequencer dut (
    .ck(ck), .res(res), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .carry_in(carry_in),
    .sel(sel), .imm(imm), .load(load), .pc(pc), .busy(busy),
    .halted(halted), .fsm_state(fsm_state)
  );

  always #5 ck = ~ck;

  // Reference machine: program image, mode flags, pc, carry.
  logic [7:0] m_mem [16];
  bit         m_run, m_halt;
  int         m_pc;
  bit         m_cf;
  // Per-opcode control table: mux select, load target, immediate used.
  int         t_sel [16];
  logic [3:0] t_ld  [16];
  bit         t_im  [16];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int op;
    op = int'(m_mem[m_pc[3:0]][7:4]);
    chk("pc", {4'd0, pc}, 8'(m_pc));
    chk("busy", {7'd0, busy}, {7'd0, m_run});
    chk("halted", {7'd0, halted}, {7'd0, m_halt});
    if (m_run) begin
      chk("sel", {6'd0, sel}, 8'(t_sel[op]));
      chk("load", {4'd0, load}, {4'd0, t_ld[op]});
      chk("imm", {4'd0, imm}, t_im[op] ? {4'd0, m_mem[m_pc[3:0]][3:0]} : 8'd0);
    end else begin
      chk("sel_idle", {6'd0, sel}, 8'd0);
      chk("load_idle", {4'd0, load}, 8'd0);
      chk("imm_idle", {4'd0, imm}, 8'd0);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then check.
  task automatic tick();
    int  op;
    bit  cf_old;
    op = int'(m_mem[m_pc[3:0]][7:4]);
    cf_old = m_cf;
    if (res) begin
      m_run = 0; m_halt = 0; m_pc = 0; m_cf = 0;
    end else if (!m_run) begin
      if (prog_we) m_mem[prog_addr] = prog_data;
      if (start) begin
        m_run = 1; m_halt = 0; m_pc = 0; m_cf = 0;
      end
    end else if (op == 8) begin
      m_run = 0; m_halt = 1;
    end else begin
      m_cf = carry_in;
      if (op == 15 || (op == 14 && !cf_old)) m_pc = int'(m_mem[m_pc[3:0]][3:0]);
      else m_pc = (m_pc + 1) % 16;
    end
    @(posedge ck);
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    res = 0; start = 0; prog_we = 0; carry_in = 0; prog_addr = 0; prog_data = 0;
  endtask

  task automatic write(input int a, input logic [7:0] d);
    prog_we = 1; prog_addr = 4'(a); prog_data = d;
    tick();
    prog_we = 0;
  endtask

  task automatic do_reset(input int cycles);
    res = 1;
    for (int i = 0; i < cycles; i++) tick();
    res = 0;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  initial begin
    logic [3:0] exp_load [5];
    logic [1:0] exp_sel  [4];
    logic [3:0] exp_imm  [4];
    for (int i = 0; i < 16; i++) begin
      t_sel[i] = 3; t_ld[i] = 4'b0000; t_im[i] = 0; m_mem[i] = 8'h00;
    end
    t_sel[0] = 0; t_ld[0] = 4'b0001; t_im[0] = 1;
    t_sel[5] = 1; t_ld[5] = 4'b0010; t_im[5] = 1;
    t_sel[3] = 3; t_ld[3] = 4'b0001; t_im[3] = 1;
    t_sel[7] = 3; t_ld[7] = 4'b0010; t_im[7] = 1;
    t_sel[1] = 1; t_ld[1] = 4'b0001;
    t_sel[4] = 0; t_ld[4] = 4'b0010;
    t_sel[2] = 2; t_ld[2] = 4'b0001;
    t_sel[6] = 2; t_ld[6] = 4'b0010;
    t_sel[9] = 1; t_ld[9] = 4'b0100;
    t_sel[11] = 3; t_ld[11] = 4'b0100; t_im[11] = 1;
    m_run = 0; m_halt = 0; m_pc = 0; m_cf = 0;
    idle_inputs();
    do_reset(2);
    chk("reset_pc", {4'd0, pc}, 8'd0);
    chk("reset_busy", {7'd0, busy}, 8'd0);
    // Fill memory so model and DUT agree on every address.
    for (int i = 0; i < 16; i++) write(i, 8'hA0);

    // Basic program.
    write(0, 8'h33); write(1, 8'h04); write(2, 8'h40); write(3, 8'h90); write(4, 8'h80);
    exp_load = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b0000};
    exp_sel  = '{2'd3, 2'd0, 2'd0, 2'd1};
    exp_imm  = '{4'd3, 4'd4, 4'd0, 4'd0};
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      chk("basic_load", {4'd0, load}, {4'd0, exp_load[i]});
      if (i < 4) begin
        chk("basic_sel", {6'd0, sel}, {6'd0, exp_sel[i]});
        chk("basic_imm", {4'd0, imm}, {4'd0, exp_imm[i]});
      end
      tick();
    end
    chk("basic_halted", {7'd0, halted}, 8'd1);
    chk("basic_pc", {4'd0, pc}, 8'd4);
    tick();
    chk("halt_holds_pc", {4'd0, pc}, 8'd4);

    // JNC with and without carry from the preceding ADD.
    for (int c = 1; c >= 0; c--) begin
      write(0, 8'h0F); write(1, 8'hE5); write(2, 8'h80); write(5, 8'h80);
      pulse_start();
      chk("jnc_pc0", {4'd0, pc}, 8'd0);
      carry_in = c[0];
      tick();
      carry_in = 0;
      chk("jnc_pc1", {4'd0, pc}, 8'd1);
      tick();
      chk("jnc_target", {4'd0, pc}, c ? 8'd2 : 8'd5);
      tick();
      do_reset(1);
    end

    // Wrap through all-NOP memory, with start ignored mid-run.
    for (int i = 0; i < 16; i++) write(i, 8'hA0);
    pulse_start();
    for (int i = 0; i < 18; i++) begin
      chk("wrap_pc", {4'd0, pc}, 8'((i) % 16));
      chk("wrap_busy", {7'd0, busy}, 8'd1);
      if (i == 7) start = 1;
      tick();
      start = 0;
    end

    // Write lockout during RUN, then reset mid-run for two cycles.
    prog_we = 1; prog_addr = 4'd2; prog_data = 8'h80;
    tick();
    prog_we = 0;
    for (int i = 0; i < 16; i++) tick();
    chk("lockout_busy", {7'd0, busy}, 8'd1);
    do_reset(2);
    chk("midrun_reset_pc", {4'd0, pc}, 8'd0);
    chk("midrun_reset_busy", {7'd0, busy}, 8'd0);
    write(2, 8'h80);
    pulse_start();
    for (int i = 0; i < 3; i++) tick();
    chk("rerun_halted", {7'd0, halted}, 8'd1);
    chk("rerun_pc", {4'd0, pc}, 8'd2);

    // start together with res, then start together with a write to address 0.
    res = 1; start = 1; tick(); res = 0; start = 0;
    chk("start_res_busy", {7'd0, busy}, 8'd0);
    prog_we = 1; prog_addr = 0; prog_data = 8'hF0; start = 1;
    tick();
    prog_we = 0; start = 0;
    for (int i = 0; i < 3; i++) begin
      chk("selfloop_load", {4'd0, load}, 8'd0);
      chk("selfloop_busy", {7'd0, busy}, 8'd1);
      tick();
    end
    do_reset(1);

    // Randomized programs and inputs.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 16; i++) write(i, 8'($urandom_range(0, 255)));
      pulse_start();
      for (int i = 0; i < 40; i++) begin
        carry_in = 1'($urandom_range(0, 1));
        start    = ($urandom_range(0, 15) == 0);
        prog_we  = ($urandom_range(0, 3) == 0);
        prog_addr = 4'($urandom_range(0, 15));
        prog_data = 8'($urandom_range(0, 255));
        res      = ($urandom_range(0, 31) == 0);
        tick();
      end
      idle_inputs();
      do_reset(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
